// File: rtl/ccip_host_mem_pkg.sv
// Shared types for the CCI-P host-memory responder: line/tag types, read-queue entry, queue FSM states.
package ccip_host_mem_pkg;

   localparam int CL_ADDR_W = 42;
   localparam int TS_W      = 8;
   localparam int XLAT_W    = 3;

   typedef logic [511:0] t_line;
   typedef logic [15:0]  t_mdata;

   // index is kept at full address width with the bits above the memory index zeroed
   typedef struct packed {
      logic [CL_ADDR_W-1:0] index;
      t_mdata               mdata;
      logic [TS_W-1:0]      timestamp;
      logic [XLAT_W-1:0]    extra;
   } t_rd_entry;

   typedef enum logic [1:0] {
      Q_EMPTY,
      Q_WAIT,
      Q_ISSUE
   } t_q_state;

endpackage

// File: rtl/ccip_host_mem_fifo.sv
// Generic synchronous FIFO with occupancy, full, empty and almost-full flags.
// Latency: pushed entry visible at head the cycle after the push.
// Backpressure: push while full is ignored unless a pop frees the slot in the same cycle.
module ccip_host_mem_fifo #(
   parameter int W             = 8,
   parameter int DEPTH         = 8,
   parameter int ALMFULL_SLACK = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic [W-1:0]               head,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       almfull
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  store [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign almfull = (count >= CW'(DEPTH - ALMFULL_SLACK));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = store[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) store[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ccip_host_mem_responder.sv
// FIU-side CCI-P memory responder; define CCIP_HOST_MEM_RAND_LAT_EN to add 0-7 cycles of LFSR read latency jitter.
// Latency: write ack 1 cycle after request; read response RD_LATENCY+1 cycles when idle, in order.
// Backpressure: c0/c1 almfull from registered queue occupancy; requests into a full queue are dropped and flagged on ovf_err.
module ccip_host_mem_responder
   import ccip_host_mem_pkg::*;
#(
   parameter int MEM_LINES     = 64,
   parameter int RD_LATENCY    = 4,
   parameter int FIFO_DEPTH    = 8,
   parameter int ALMFULL_SLACK = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 c0_req_valid,
   input  logic [CL_ADDR_W-1:0] c0_req_addr,
   input  logic [15:0]          c0_req_mdata,
   input  logic                 c1_req_valid,
   input  logic [CL_ADDR_W-1:0] c1_req_addr,
   input  logic [15:0]          c1_req_mdata,
   input  logic [511:0]         c1_req_data,
   output logic                 c0_rsp_valid,
   output logic [15:0]          c0_rsp_mdata,
   output logic [511:0]         c0_rsp_data,
   output logic                 c1_rsp_valid,
   output logic [15:0]          c1_rsp_mdata,
   output logic                 c0_almfull,
   output logic                 c1_almfull,
   output logic                 ovf_err
);

   localparam int IDX_W = $clog2(MEM_LINES);
   localparam int CW    = $clog2(FIFO_DEPTH) + 1;

   t_line              mem [MEM_LINES];
   logic [TS_W-1:0]    ts_cnt;
   logic [XLAT_W-1:0]  extra_lat;

   t_rd_entry          rd_in;
   t_rd_entry          rd_head;
   logic               rd_full, rd_empty, rd_pop, rd_aged;
   logic [CW-1:0]      rd_count;
   logic [TS_W-1:0]    rd_age;
   logic [31:0]        rd_need;

   t_mdata             ack_head;
   logic               ack_full, ack_empty, ack_push, ack_pop, ack_bypass, ack_issue;
   logic [CW-1:0]      ack_count;

   t_q_state           rd_state, rd_next;
   t_q_state           ack_state, ack_next;
   logic               ovf_now;
   logic               unused_bits;

`ifdef CCIP_HOST_MEM_RAND_LAT_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr <= 16'hACE1;
      else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign extra_lat = lfsr[2:0];
`else
   assign extra_lat = '0;
`endif

   always_comb begin
      rd_in           = '0;
      rd_in.index     = CL_ADDR_W'(c0_req_addr[IDX_W-1:0]);
      rd_in.mdata     = c0_req_mdata;
      rd_in.timestamp = ts_cnt;
      rd_in.extra     = extra_lat;
   end

   // Age is modulo-256; a head never waits longer than RD_LATENCY+7 so it cannot alias.
   assign rd_age  = ts_cnt - rd_head.timestamp;
   assign rd_need = 32'(RD_LATENCY) + 32'(rd_head.extra);
   assign rd_aged = (32'(rd_age) >= rd_need);
   assign rd_pop  = !rd_empty && rd_aged;

   ccip_host_mem_fifo #(
      .W             ($bits(t_rd_entry)),
      .DEPTH         (FIFO_DEPTH),
      .ALMFULL_SLACK (ALMFULL_SLACK)
   ) u_rd_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (c0_req_valid),
      .push_data (rd_in),
      .pop       (rd_pop),
      .head      (rd_head),
      .count     (rd_count),
      .full      (rd_full),
      .empty     (rd_empty),
      .almfull   (c0_almfull)
   );

   // An ack into an empty queue skips it so the earliest ack lands one cycle after the write.
   assign ack_bypass = c1_req_valid && ack_empty;
   assign ack_push   = c1_req_valid && !ack_empty;
   assign ack_pop    = !ack_empty;
   assign ack_issue  = ack_pop || ack_bypass;

   ccip_host_mem_fifo #(
      .W             ($bits(t_mdata)),
      .DEPTH         (FIFO_DEPTH),
      .ALMFULL_SLACK (ALMFULL_SLACK)
   ) u_ack_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (ack_push),
      .push_data (c1_req_mdata),
      .pop       (ack_pop),
      .head      (ack_head),
      .count     (ack_count),
      .full      (ack_full),
      .empty     (ack_empty),
      .almfull   (c1_almfull)
   );

   assign ovf_now = (c0_req_valid && rd_full && !rd_pop) ||
                    (ack_push && ack_full && !ack_pop);

   // ISSUE means the queue popped last cycle, so the response register holds a live entry.
   always_comb begin
      rd_next  = rd_state;
      ack_next = ack_state;

      unique case (rd_state)
         Q_EMPTY: if (c0_req_valid) rd_next = Q_WAIT;
         Q_WAIT:  if (rd_pop) rd_next = Q_ISSUE;
         Q_ISSUE: begin
            if (rd_pop)                         rd_next = Q_ISSUE;
            else if (rd_empty && !c0_req_valid) rd_next = Q_EMPTY;
            else                                rd_next = Q_WAIT;
         end
         default: rd_next = Q_EMPTY;
      endcase

      unique case (ack_state)
         Q_EMPTY: if (ack_issue) ack_next = Q_ISSUE;
         Q_WAIT:  if (ack_issue) ack_next = Q_ISSUE;
         Q_ISSUE: begin
            if (ack_issue)      ack_next = Q_ISSUE;
            else if (ack_empty) ack_next = Q_EMPTY;
            else                ack_next = Q_WAIT;
         end
         default: ack_next = Q_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_state     <= Q_EMPTY;
         ack_state    <= Q_EMPTY;
         ts_cnt       <= '0;
         c0_rsp_mdata <= '0;
         c0_rsp_data  <= '0;
         c1_rsp_mdata <= '0;
         ovf_err      <= 1'b0;
      end else begin
         rd_state  <= rd_next;
         ack_state <= ack_next;
         ts_cnt    <= ts_cnt + TS_W'(1);
         if (rd_pop) begin
            c0_rsp_mdata <= rd_head.mdata;
            c0_rsp_data  <= mem[rd_head.index[IDX_W-1:0]];
         end
         if (ack_issue) c1_rsp_mdata <= ack_empty ? c1_req_mdata : ack_head;
         if (ovf_now)   ovf_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (c1_req_valid) mem[c1_req_addr[IDX_W-1:0]] <= c1_req_data;
   end

   assign c0_rsp_valid = (rd_state == Q_ISSUE);
   assign c1_rsp_valid = (ack_state == Q_ISSUE);

   assign unused_bits = ^{c0_req_addr[CL_ADDR_W-1:IDX_W], c1_req_addr[CL_ADDR_W-1:IDX_W],
                          rd_head.index[CL_ADDR_W-1:IDX_W], rd_count, ack_count};

endmodule
